addsub_wb_stage: RTL and testbench
==================================

Name: addsub_wb_stage

Overview:
- Writeback/result-buffer stage directly downstream of the 8-bit add/sub unit.
- Captures the combinational sum and flags (cf, ovf, sf, zf) through a valid/ready handshake and buffers them in a small FIFO for the consumer.
- Maintains an architectural PSW of the last accepted flags, a sticky overflow bit, a saturating operation counter, and a flag-consistency checker.

Parameters:
- WIDTH, 8, data width of sum; matches the add/sub unit.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of op_count.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_sum  input  WIDTH  result from add/sub unit.
- in_cf, in_ovf, in_sf, in_zf  input  1 each  flags from add/sub unit.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- out_sum  output  WIDTH  head sum.
- out_flags  output  4  head flags {cf,ovf,sf,zf}.
- psw  output  4  flags {cf,ovf,sf,zf} of last accepted entry.
- sticky_ovf  output  1  set by any accepted ovf=1.
- sticky_clr  input  1  clears sticky_ovf.
- op_count  output  CNT_W  accepted-entry count, saturating.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- flag_err  output  1  one-cycle pulse on inconsistent accepted flags.

Behaviour:
- Reset (rst=1 at edge): FIFO emptied, level=0, psw=0, sticky_ovf=0, op_count=0, flag_err=0. in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- Accept: push = in_valid & in_ready. Pop: pop = out_valid & out_ready.
- in_ready = !rst & (level != DEPTH). It does not depend on out_ready, so there is no push-through when full.
- out_valid = (level != 0). out_sum/out_flags show the head entry when valid and are driven to 0 when out_valid=0.
- Latency: an entry pushed at edge N is visible on out_* in cycle N+1. There is no combinational fall-through.
- Order is strict FIFO. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: level is unchanged and both take effect. When empty, only a push is possible.
- psw: on push, loaded with {in_cf,in_ovf,in_sf,in_zf}. It is visible the cycle after the push and holds otherwise.
- sticky_ovf: set on push with in_ovf=1, cleared by sticky_clr. If set and clear occur in the same cycle, set wins.
- op_count: +1 per push. It holds at 2^CNT_W-1 and does not wrap.
- flag_err: registered. Pulses high the cycle after a push where in_zf != (in_sum==0) or in_sf != in_sum[WIDTH-1]. The entry is still stored unmodified.
- Reset mid-operation: all buffered entries are discarded. out_valid=0 and out_sum/out_flags=0 the cycle after the reset edge.

Decomposition:
- Shared package addsub_pkg:
  - Constants FLAG_CF=3, FLAG_OVF=2, FLAG_SF=1, FLAG_ZF=0.
  - Typedef flags_t (4-bit packed {cf,ovf,sf,zf}).
  - Typedef wb_entry_t {sum, flags}.
- One sub-module, sync_fifo: parameterised width/depth, synchronous reset, push/pop/level/full/empty. The stage instantiates it with width WIDTH+4 and adds the PSW, sticky, counter and checker logic around it.

Test Plan:
- Reset then single push of sum=0x0C, flags=0000 -> in_ready=1 from first post-reset cycle; next cycle out_valid=1, out_sum=0x0C, out_flags=0000, psw=0000, op_count=1.
- With out_ready=0, push 0x7F then 0x80 (ovf=1, sf=1) -> level=2, in_ready=0; third in_valid is not accepted; sticky_ovf=1; psw=0110; draining yields 0x7F, then 0x80.
- Full FIFO with out_ready=1 and in_valid=1 -> one pop per cycle. Push is accepted only after level drops below DEPTH (no same-cycle push when full). Order is preserved across pointer wrap over 10 entries.
- sticky_clr=1 in the same cycle as a push with ovf=1 -> sticky_ovf stays 1. sticky_clr alone the next cycle -> sticky_ovf=0.
- Push sum=0x00 with zf=0 -> flag_err pulses for exactly one cycle. The entry is stored with zf=0 unchanged.
- Preload op_count near saturation (CNT_W=4 build, 16 pushes) -> holds at 15. Assert rst with level=2 -> level=0, out_valid=0, psw=0 the next cycle.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub unit and its writeback stage.
// Flags are always carried as a packed {cf, ovf, sf, zf} nibble.
package addsub_pkg;

  localparam int DATA_W   = 8;
  localparam int FLAG_CF  = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_SF  = 1;
  localparam int FLAG_ZF  = 0;

  typedef logic [3:0] flags_t;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    flags_t            flags;
  } wb_entry_t;

  function automatic flags_t pack_flags(input logic cf, input logic ovf,
                                        input logic sf, input logic zf);
    flags_t f;
    f           = '0;
    f[FLAG_CF]  = cf;
    f[FLAG_OVF] = ovf;
    f[FLAG_SF]  = sf;
    f[FLAG_ZF]  = zf;
    return f;
  endfunction

endpackage

// File: rtl/addsub_wb_stage_if.sv
// Result handshake between the add/sub unit, the writeback stage and its consumer.
// The stage takes the slave view; the producer/consumer side takes the master view.
interface addsub_wb_stage_if #(
  parameter int WIDTH = 8
);
  import addsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cf;
  logic             in_ovf;
  logic             in_sf;
  logic             in_zf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  flags_t           out_flags;

  modport master (
    output in_valid, in_sum, in_cf, in_ovf, in_sf, in_zf, out_ready,
    input  in_ready, out_valid, out_sum, out_flags
  );

  modport slave (
    input  in_valid, in_sum, in_cf, in_ovf, in_sf, in_zf, out_ready,
    output in_ready, out_valid, out_sum, out_flags
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; DEPTH must be a power of two.
// Push when full and pop when empty are ignored; pop_data is the head entry.
module sync_fifo #(
  parameter  int W     = 12,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within or across blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only ever
  // read behind a valid level, so clearing it would cost reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/addsub_wb_stage.sv
// Writeback stage after the add/sub unit: buffers {sum, flags} in a FIFO and keeps
// the PSW, a sticky overflow bit, a saturating op counter and a flag checker.
module addsub_wb_stage
  import addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  parameter  int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  addsub_wb_stage_if.slave       bus,
  output flags_t                 psw,
  output logic                   sticky_ovf,
  input  logic                   sticky_clr,
  output logic [CNT_W-1:0]       op_count,
  output logic [LVL_W-1:0]       level,
  output logic                   flag_err
);

  localparam int ENTRY_W = WIDTH + 4;

  flags_t             in_flags;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               flags_bad;

  assign in_flags = pack_flags(bus.in_cf, bus.in_ovf, bus.in_sf, bus.in_zf);

  // Readiness only looks at occupancy, never at out_ready: no push-through when full.
  assign bus.in_ready  = !rst && !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out_sum   = bus.out_valid ? head[ENTRY_W-1:4] : '0;
  assign bus.out_flags = bus.out_valid ? flags_t'(head[3:0]) : '0;

  assign flags_bad = (in_flags[FLAG_ZF] != (bus.in_sum == '0)) ||
                     (in_flags[FLAG_SF] != bus.in_sum[WIDTH-1]);

  sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.in_sum, in_flags}),
    .pop       (pop),
    .pop_data  (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      psw        <= '0;
      sticky_ovf <= 1'b0;
      op_count   <= '0;
      flag_err   <= 1'b0;
    end else begin
      if (push) psw <= in_flags;

      // A new overflow outranks a concurrent clear so it cannot be lost.
      if (push && in_flags[FLAG_OVF]) sticky_ovf <= 1'b1;
      else if (sticky_clr)            sticky_ovf <= 1'b0;

      if (push && (op_count != '1)) op_count <= op_count + 1'b1;

      flag_err <= push && flags_bad;
    end
  end

endmodule

// File: tb/tb_addsub_wb_stage.sv
// Directed bench for addsub_wb_stage (DEPTH=2, CNT_W=4 so saturation is reachable).
// Inputs change 1ns after the rising edge; outputs are sampled in the same window.
module tb_addsub_wb_stage;
  import addsub_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sticky_clr = 1'b0;
  flags_t           psw;
  logic             sticky_ovf;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       level;
  logic             flag_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  addsub_wb_stage_if #(.WIDTH(WIDTH)) bus ();

  addsub_wb_stage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .psw        (psw),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr),
    .op_count   (op_count),
    .level      (level),
    .flag_err   (flag_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [7:0] s, input flags_t f);
    bus.in_valid = v;
    bus.in_sum   = s;
    {bus.in_cf, bus.in_ovf, bus.in_sf, bus.in_zf} = f;
  endtask

  wb_entry_t  q[$];
  wb_entry_t  e;
  int         pushed;
  logic       do_push;
  logic       do_pop;

  initial begin
    bus.out_ready = 1'b0;
    drive_in(1'b0, 8'h00, 4'b0000);

    // Reset state
    step();
    step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_level", level, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_psw", psw, 0);
    check("rst_op_count", op_count, 0);
    check("rst_sticky", sticky_ovf, 0);
    check("rst_flag_err", flag_err, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Single push, visible one cycle later
    drive_in(1'b1, 8'h0C, 4'b0000);
    step();
    drive_in(1'b0, 8'h00, 4'b0000);
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_out_sum", bus.out_sum, 8'h0C);
    check("t1_out_flags", bus.out_flags, 4'b0000);
    check("t1_psw", psw, 4'b0000);
    check("t1_op_count", op_count, 1);
    check("t1_level", level, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t1_empty_valid", bus.out_valid, 0);
    check("t1_empty_sum", bus.out_sum, 0);
    check("t1_empty_flags", bus.out_flags, 0);

    // Fill to DEPTH, third request refused
    drive_in(1'b1, 8'h7F, 4'b0000);
    step();
    drive_in(1'b1, 8'h80, 4'b0110);
    step();
    check("t2_flag_err_ok", flag_err, 0);
    drive_in(1'b1, 8'h55, 4'b0000);
    #1;
    check("t2_in_ready_full", bus.in_ready, 0);
    check("t2_level", level, 2);
    check("t2_sticky", sticky_ovf, 1);
    check("t2_psw", psw, 4'b0110);
    check("t2_op_count", op_count, 3);
    step();
    check("t2_level_hold", level, 2);
    check("t2_op_count_hold", op_count, 3);
    drive_in(1'b0, 8'h00, 4'b0000);
    bus.out_ready = 1'b1;
    check("t2_drain0_sum", bus.out_sum, 8'h7F);
    check("t2_drain0_flags", bus.out_flags, 4'b0000);
    step();
    check("t2_drain1_sum", bus.out_sum, 8'h80);
    check("t2_drain1_flags", bus.out_flags, 4'b0110);
    check("t2_drain1_level", level, 1);
    step();
    check("t2_drained", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Stream 10 entries from a full FIFO across pointer wrap
    q.delete();
    drive_in(1'b1, 8'h10, 4'b0000);
    step();
    drive_in(1'b1, 8'h11, 4'b0000);
    step();
    e.sum = 8'h10; e.flags = 4'b0000; q.push_back(e);
    e.sum = 8'h11; q.push_back(e);
    pushed = 2;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && (q.size() != 0 || pushed < 10); cyc++) begin
      drive_in(pushed < 10, 8'(8'h10 + pushed), 4'b0000);
      #1;
      check("stream_level", level, q.size());
      check("stream_in_ready", bus.in_ready, q.size() != DEPTH);
      if (q.size() != 0) check("stream_sum", bus.out_sum, q[0].sum);
      do_push = bus.in_valid && (q.size() != DEPTH);
      do_pop  = (q.size() != 0);
      e.sum = bus.in_sum;
      step();
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        pushed++;
      end
    end
    check("stream_done", (pushed == 10) && (q.size() == 0), 1);
    drive_in(1'b0, 8'h00, 4'b0000);
    bus.out_ready = 1'b0;

    // Sticky overflow: set beats clear
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("t4_clear", sticky_ovf, 0);
    drive_in(1'b1, 8'h05, 4'b0100);
    sticky_clr = 1'b1;
    step();
    check("t4_set_wins", sticky_ovf, 1);
    drive_in(1'b0, 8'h00, 4'b0000);
    step();
    sticky_clr = 1'b0;
    check("t4_clear_alone", sticky_ovf, 0);
    bus.out_ready = 1'b1;
    check("t4_entry_sum", bus.out_sum, 8'h05);
    check("t4_entry_flags", bus.out_flags, 4'b0100);
    step();
    bus.out_ready = 1'b0;

    // Flag checker: bad zf, then bad sf
    drive_in(1'b1, 8'h00, 4'b0000);
    step();
    drive_in(1'b0, 8'h00, 4'b0000);
    check("t5_zf_err", flag_err, 1);
    check("t5_stored_valid", bus.out_valid, 1);
    check("t5_stored_sum", bus.out_sum, 8'h00);
    check("t5_stored_flags", bus.out_flags, 4'b0000);
    drive_in(1'b1, 8'h81, 4'b0000);
    bus.out_ready = 1'b1;
    step();
    drive_in(1'b0, 8'h00, 4'b0000);
    check("t5_sf_err", flag_err, 1);
    check("t5_sf_stored", bus.out_sum, 8'h81);
    step();
    check("t5_err_pulse_end", flag_err, 0);
    bus.out_ready = 1'b0;

    // Counter saturation from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_cnt_reset", op_count, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_in(1'b1, 8'(8'h20 + i), 4'b0000);
      step();
      check("t6_op_count", op_count, (i + 1 > 15) ? 15 : i + 1);
    end
    drive_in(1'b0, 8'h00, 4'b0000);
    step();
    bus.out_ready = 1'b0;

    // Reset with two entries buffered
    drive_in(1'b1, 8'h30, 4'b1000);
    step();
    drive_in(1'b1, 8'h31, 4'b1000);
    step();
    drive_in(1'b0, 8'h00, 4'b0000);
    check("t7_level_full", level, 2);
    check("t7_psw", psw, 4'b1000);
    rst = 1'b1;
    #1;
    check("t7_in_ready_rst", bus.in_ready, 0);
    step();
    check("t7_level", level, 0);
    check("t7_out_valid", bus.out_valid, 0);
    check("t7_out_sum", bus.out_sum, 0);
    check("t7_out_flags", bus.out_flags, 0);
    check("t7_psw_clr", psw, 0);
    check("t7_op_count", op_count, 0);
    rst = 1'b0;
    #1;
    check("t7_in_ready_after", bus.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
